bird_judge: RTL
===============

Name: bird_judge

Overview:
- Parametrised game-outcome judge for the bird/tree minigame. It is the successor to the single-life win/die checker.
- Compares the bird row against the obstacle row at the bird's column once per slow tick.
- Tracks lives and trees passed. Declares WIN when the score reaches a target and LOSE when lives are exhausted.
- Sits between the bird-movement/tree-scroll logic and the display/score drivers.

Parameters:
- WIDTH, 16: bit width of the bird and obstacle rows.
- TICK_DIV, 1024: clocks per evaluation tick. Must be >= 2.
- LIVES, 3: lives at game start. Must be >= 1.
- TARGET, 8: trees passed needed to win. Must be >= 1.
- GRACE_TICKS, 4: invulnerable ticks after a non-fatal hit. Used only with GRACE_EN.

Ports:
- clock  in  1  system clock.
- reset  in  1  see Behaviour.
- bird  in  WIDTH  bird occupancy in the column meeting the obstacles.
- obstacle  in  WIDTH  obstacle occupancy in that same column.
- pass  in  1  pulse: one tree has cleared the bird. May arrive on any clock.
- restart  in  1  start a new game from WIN or LOSE.
- tick  out  1  one-clock strobe marking each evaluation tick.
- hit  out  1  one-clock pulse when a life is lost.
- lives  out  $clog2(LIVES+1)  remaining lives.
- score  out  $clog2(TARGET+1)  trees passed this game.
- win  out  1  level, high while in WIN.
- lose  out  1  level, high while in LOSE.

Behaviour:
- Reset: reset, synchronous, active-high; clock clock. Reset sets:
  - divider = 0, state = PLAY, lives = LIVES, score = 0;
  - pass_pending = 0, grace counter = 0;
  - tick = hit = win = lose = 0.
- Divider:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - tick is high for the one clock in which the count equals TICK_DIV-1.
  - The divider runs in every state.
- pass_pending:
  - A sticky flag, set on any clock with pass = 1.
  - Cleared on the clock after a tick that consumes it.
  - Several passes between two ticks count as one.
  - A pass arriving on the tick clock itself is consumed by that tick.
- crash = ((bird & obstacle) != 0) OR (bird == 0). bird == 0 means the bird has fallen off the map.
- States: PLAY, GRACE (exists only with GRACE_EN), WIN, LOSE.
- PLAY, on a tick clock, with this priority:
  1. crash and lives == 1: lives -> 0, hit pulses, go to LOSE.
  2. crash and lives > 1: lives decrements, hit pulses. Go to GRACE if enabled, otherwise stay in PLAY.
  3. No crash and pass_pending: score increments. If the new score == TARGET, go to WIN.
  4. Otherwise no change.
- Crash on a tick: the pending pass is discarded (cleared, not scored).
- Timing: every register update takes effect on the clock after the tick clock. hit is high exactly that one clock.
- PLAY, off tick: only the divider and pass_pending change.
- WIN/LOSE:
  - lives and score hold; pass is ignored and pass_pending is held at 0.
  - restart = 1 on any clock (not gated by tick) reloads lives = LIVES, score = 0, pass_pending = 0 and returns to PLAY on the next clock.
  - The divider is not reset by restart.
- restart in PLAY or GRACE is ignored.
- Simultaneous reset and restart: reset wins.
- Saturation: score never exceeds TARGET and lives never go below 0. Both hold by construction of the state machine.

Optional Feature:
- Macro BIRD_JUDGE_GRACE_EN.
- When defined:
  - A non-fatal hit enters GRACE with the grace counter = GRACE_TICKS.
  - In GRACE, crash is ignored on ticks and passes still score, so WIN from GRACE is possible.
  - Each tick decrements the counter; the tick that reaches 0 returns to PLAY.
- When undefined:
  - The GRACE state and its counter do not exist.
  - A sustained overlap costs one life per tick.

Test Plan (TICK_DIV=4, LIVES=3, TARGET=2, WIDTH=16):
- Clean pass: bird=16'h0100, obstacle=16'hFC7F, pass pulsed once between ticks -> score=1 after the next tick, lives=3, hit never high.
- Win: two separate pass pulses, no overlap -> score=2, win=1 on the clock after the second scoring tick. A further pass leaves score at 2.
- Crash and lose, macro off: bird=16'h1000, obstacle=16'hFC7F held -> lives 3,2,1,0 on three consecutive ticks, hit pulses each time, lose=1 after the third.
- Fall off: bird=16'h0000 on a tick with pass_pending=1 -> lives decrements, score unchanged, pending cleared.
- Restart: in LOSE assert restart for one clock -> next clock lives=3, score=0, lose=0, state PLAY. restart in PLAY -> no change.
- Grace, macro on, GRACE_TICKS=2: overlap held -> one hit (lives=2), no further hit for the 2 grace ticks, the next hit comes on the first tick back in PLAY. Reset asserted mid-grace -> PLAY, lives=3.

Source files
------------

// File: rtl/bird_judge.sv
// bird_judge: game-outcome judge for the bird/tree minigame.
// Once per evaluation tick it compares the bird row with the obstacle row,
// tracks lives and trees passed, and declares WIN or LOSE.
// Optional build macro: BIRD_JUDGE_GRACE_EN adds a post-hit invulnerable
// GRACE state lasting GRACE_TICKS ticks.
module bird_judge #(
  parameter int WIDTH       = 16,
  parameter int TICK_DIV    = 1024,
  parameter int LIVES       = 3,
  parameter int TARGET      = 8,
  parameter int GRACE_TICKS = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           bird,
  input  logic [WIDTH-1:0]           obstacle,
  input  logic                       pass,
  input  logic                       restart,
  output logic                       tick,
  output logic                       hit,
  output logic [$clog2(LIVES+1)-1:0] lives,
  output logic [$clog2(TARGET+1)-1:0] score,
  output logic                       win,
  output logic                       lose
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LIV_W = $clog2(LIVES + 1);
  localparam int SCR_W = $clog2(TARGET + 1);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [LIV_W-1:0] LIVES_INIT = LIV_W'(LIVES);
  localparam logic [LIV_W-1:0] LIFE_ONE   = LIV_W'(1);
  localparam logic [SCR_W-1:0] TARGET_V   = SCR_W'(TARGET);

  // Elaboration-time parameter sanity checks.
  if (TICK_DIV < 2) begin : g_bad_div
    $error("bird_judge: TICK_DIV must be >= 2");
  end
  if (LIVES < 1) begin : g_bad_lives
    $error("bird_judge: LIVES must be >= 1");
  end
  if (TARGET < 1) begin : g_bad_target
    $error("bird_judge: TARGET must be >= 1");
  end
`ifdef BIRD_JUDGE_GRACE_EN
  if (GRACE_TICKS < 1) begin : g_bad_grace
    $error("bird_judge: GRACE_TICKS must be >= 1 when grace is enabled");
  end
`else
  if (GRACE_TICKS < 0) begin : g_bad_grace
    $error("bird_judge: GRACE_TICKS must not be negative");
  end
`endif

`ifdef BIRD_JUDGE_GRACE_EN
  localparam int GR_W = $clog2(GRACE_TICKS + 1);
  localparam logic [GR_W-1:0] GRACE_INIT = GR_W'(GRACE_TICKS);
  localparam logic [GR_W-1:0] GRACE_ONE  = GR_W'(1);

  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_GRACE = 2'd1,
    S_WIN   = 2'd2,
    S_LOSE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_WIN   = 2'd2,
    S_LOSE  = 2'd3
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [LIV_W-1:0]  lives_q, lives_d;
  logic [SCR_W-1:0]  score_q, score_d;
  logic              pend_q, pend_d;
  logic              hit_q, hit_d;
`ifdef BIRD_JUDGE_GRACE_EN
  logic [GR_W-1:0]   grace_q, grace_d;
`endif

  logic              tick_w;
  logic              crash;
  logic              pend_eff;
  logic [SCR_W-1:0]  score_inc;

  // Free-running tick divider and combinational helpers.
  always_comb begin
    tick_w    = (div_q == DIV_LAST);
    div_d     = tick_w ? '0 : div_q + 1'b1;
    crash     = (|(bird & obstacle)) || (bird == '0);
    // A pass on the tick clock itself is folded into the pending flag.
    pend_eff  = pend_q | pass;
    score_inc = score_q + 1'b1;
  end

  // Game state machine: next-state, life/score bookkeeping and hit request.
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    score_d = score_q;
    pend_d  = pend_eff;
    hit_d   = 1'b0;
`ifdef BIRD_JUDGE_GRACE_EN
    grace_d = grace_q;
`endif
    unique case (state_q)
      S_PLAY: begin
        if (tick_w) begin
          // Every tick consumes the pending pass; a crash discards it.
          pend_d = 1'b0;
          if (crash) begin
            hit_d = 1'b1;
            if (lives_q == LIFE_ONE) begin
              lives_d = '0;
              state_d = S_LOSE;
            end else begin
              lives_d = lives_q - 1'b1;
`ifdef BIRD_JUDGE_GRACE_EN
              state_d = S_GRACE;
              grace_d = GRACE_INIT;
`endif
            end
          end else if (pend_eff) begin
            score_d = score_inc;
            if (score_inc == TARGET_V) begin
              state_d = S_WIN;
            end
          end
        end
      end
`ifdef BIRD_JUDGE_GRACE_EN
      S_GRACE: begin
        if (tick_w) begin
          pend_d  = 1'b0;
          grace_d = grace_q - 1'b1;
          if (pend_eff && (score_inc == TARGET_V)) begin
            score_d = score_inc;
            state_d = S_WIN;
            grace_d = '0;
          end else begin
            if (pend_eff) begin
              score_d = score_inc;
            end
            if (grace_q == GRACE_ONE) begin
              state_d = S_PLAY;
            end
          end
        end
      end
`endif
      S_WIN, S_LOSE: begin
        pend_d = 1'b0;
        if (restart) begin
          lives_d = LIVES_INIT;
          score_d = '0;
          state_d = S_PLAY;
        end
      end
      default: begin
        state_d = S_PLAY;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q   <= '0;
      state_q <= S_PLAY;
      lives_q <= LIVES_INIT;
      score_q <= '0;
      pend_q  <= 1'b0;
      hit_q   <= 1'b0;
`ifdef BIRD_JUDGE_GRACE_EN
      grace_q <= '0;
`endif
    end else begin
      div_q   <= div_d;
      state_q <= state_d;
      lives_q <= lives_d;
      score_q <= score_d;
      pend_q  <= pend_d;
      hit_q   <= hit_d;
`ifdef BIRD_JUDGE_GRACE_EN
      grace_q <= grace_d;
`endif
    end
  end

  // Output decode.
  always_comb begin
    tick  = tick_w;
    hit   = hit_q;
    lives = lives_q;
    score = score_q;
    win   = (state_q == S_WIN);
    lose  = (state_q == S_LOSE);
  end

endmodule
